// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU issue path.
// The datapath constants below are the defaults for every module that imports this package.
package alu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int IMM_W  = 16;

    typedef enum logic [3:0] {
        ALU_RTYPE  = 4'b0000,
        ALU_ADDI   = 4'b0001,
        ALU_ANDI   = 4'b0010,
        ALU_ORI    = 4'b0011,
        ALU_XORI   = 4'b0100,
        ALU_SLTI   = 4'b0101,
        ALU_SLTIU  = 4'b0110,
        ALU_LUI    = 4'b0111,
        ALU_MEM    = 4'b1000,
        ALU_BRANCH = 4'b1001
    } alu_op_e;

    typedef enum logic [5:0] {
        FN_ADD = 6'b000000,
        FN_SUB = 6'b000001,
        FN_AND = 6'b000010,
        FN_OR  = 6'b000011,
        FN_XOR = 6'b000100,
        FN_SLL = 6'b000101,
        FN_SRL = 6'b000110,
        FN_SRA = 6'b000111,
        FN_SLT = 6'b001000
    } alu_func_e;

    typedef struct packed {
        logic [3:0]        aluop;
        logic [5:0]        func;
        logic [XLEN-1:0]   inp1;
        logic [XLEN-1:0]   inp2;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              use_imm;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
    } issue_entry_t;

    function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/alu_operand_fwd.sv
// Combinational match/replace of one operand from the result bus; built only with ALU_FWD_EN.
// Zero latency, no state; index 0 never matches since it is the hardwired zero register.
`ifdef ALU_FWD_EN
module alu_operand_fwd
    import alu_pkg::*;
#(
    parameter int W  = XLEN,
    parameter int AW = REG_AW
) (
    input  logic          enable,
    input  logic [AW-1:0] rs,
    input  logic [W-1:0]  data_in,
    input  logic          fwd_valid,
    input  logic [AW-1:0] fwd_rd,
    input  logic [W-1:0]  fwd_data,
    output logic [W-1:0]  data_out
);

    logic hit;

    assign hit      = enable && fwd_valid && (fwd_rd != '0) && (fwd_rd == rs);
    assign data_out = hit ? fwd_data : data_in;

endmodule
`endif

// File: rtl/alu_issue_stage.sv
// ALU issue stage: two-slot skid buffer (main + skid), 1-cycle accept-to-out_valid, full rate under
// backpressure; in_ready depends only on skid occupancy. Operand forwarding is enabled by ALU_FWD_EN.
module alu_issue_stage #(
    parameter int XLEN   = alu_pkg::XLEN,
    parameter int REG_AW = alu_pkg::REG_AW,
    parameter int IMM_W  = alu_pkg::IMM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_aluop,
    input  logic [5:0]        in_func,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_use_imm,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_reg_write,
    input  logic              flush,
    input  logic              fwd_valid,
    input  logic [REG_AW-1:0] fwd_rd,
    input  logic [XLEN-1:0]   fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_inp1,
    output logic [XLEN-1:0]   out_inp2,
    output logic [3:0]        out_aluop,
    output logic [5:0]        out_func,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_write
);

    import alu_pkg::*;

    issue_entry_t    main_q, skid_q;
    issue_entry_t    in_entry, main_cur, skid_cur;
    logic            main_vld, skid_vld;
    logic            accept, fire;
    logic [XLEN-1:0] rs1_sel, rs2_sel;
    logic [XLEN-1:0] main_inp1_f, main_inp2_f, skid_inp1_f, skid_inp2_f;

    assign in_ready = !skid_vld;
    assign accept   = in_valid && in_ready;
    assign fire     = main_vld && out_ready;

`ifdef ALU_FWD_EN
    alu_operand_fwd #(.W(XLEN), .AW(REG_AW)) u_cap_rs1 (
        .enable(1'b1), .rs(in_rs1), .data_in(in_rs1_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .data_out(rs1_sel)
    );
    alu_operand_fwd #(.W(XLEN), .AW(REG_AW)) u_cap_rs2 (
        .enable(!in_use_imm), .rs(in_rs2), .data_in(in_rs2_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .data_out(rs2_sel)
    );
    alu_operand_fwd #(.W(XLEN), .AW(REG_AW)) u_main_rs1 (
        .enable(1'b1), .rs(main_q.rs1), .data_in(main_q.inp1),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .data_out(main_inp1_f)
    );
    alu_operand_fwd #(.W(XLEN), .AW(REG_AW)) u_main_rs2 (
        .enable(!main_q.use_imm), .rs(main_q.rs2), .data_in(main_q.inp2),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .data_out(main_inp2_f)
    );
    alu_operand_fwd #(.W(XLEN), .AW(REG_AW)) u_skid_rs1 (
        .enable(1'b1), .rs(skid_q.rs1), .data_in(skid_q.inp1),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .data_out(skid_inp1_f)
    );
    alu_operand_fwd #(.W(XLEN), .AW(REG_AW)) u_skid_rs2 (
        .enable(!skid_q.use_imm), .rs(skid_q.rs2), .data_in(skid_q.inp2),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .data_out(skid_inp2_f)
    );
`else
    logic unused_fwd;

    assign unused_fwd  = ^{fwd_valid, fwd_rd, fwd_data, in_rs1, in_rs2};
    assign rs1_sel     = in_rs1_data;
    assign rs2_sel     = in_rs2_data;
    assign main_inp1_f = main_q.inp1;
    assign main_inp2_f = main_q.inp2;
    assign skid_inp1_f = skid_q.inp1;
    assign skid_inp2_f = skid_q.inp2;
`endif

    always_comb begin
        in_entry           = '0;
        in_entry.aluop     = in_aluop;
        in_entry.func      = in_func;
        in_entry.inp1      = rs1_sel;
        in_entry.inp2      = in_use_imm ? sext_imm(in_imm) : rs2_sel;
        in_entry.use_imm   = in_use_imm;
        in_entry.rd        = in_rd;
        in_entry.reg_write = in_reg_write;
`ifdef ALU_FWD_EN
        in_entry.rs1       = in_rs1;
        in_entry.rs2       = in_rs2;
`endif
    end

    // Held entries as they would look after this cycle's result-bus snoop.
    always_comb begin
        main_cur      = main_q;
        main_cur.inp1 = main_inp1_f;
        main_cur.inp2 = main_inp2_f;
        skid_cur      = skid_q;
        skid_cur.inp1 = skid_inp1_f;
        skid_cur.inp2 = skid_inp2_f;
    end

    // An occupied skid forces in_ready low, so a skid->main move never coincides with an accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!main_vld || fire) begin
            if (skid_vld) begin
                main_q   <= skid_cur;
                main_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                main_vld <= accept;
                if (accept) begin
                    main_q <= in_entry;
                end
            end
        end else begin
            main_q <= main_cur;
            if (accept) begin
                skid_q   <= in_entry;
                skid_vld <= 1'b1;
            end else begin
                skid_q   <= skid_cur;
            end
        end
    end

    assign out_valid     = main_vld;
    assign out_inp1      = main_q.inp1;
    assign out_inp2      = main_q.inp2;
    assign out_aluop     = main_q.aluop;
    assign out_func      = main_q.func;
    assign out_rd        = main_q.rd;
    assign out_reg_write = main_q.reg_write;

endmodule
